// File: rtl/serial_async_rx.sv
// Asynchronous serial receiver: synchronises the line, filters the start edge,
// samples every bit at its centre, and reports each word with a one-cycle strobe.
module serial_async_rx #(
   parameter int   MAIN_CLK_HZ     = 50_000_000,
   parameter int   SERIAL_CLK_HZ   = 9_600,
   parameter logic SERIAL_INACTIVE = 1'b1,
   parameter logic SERIAL_START    = 1'b0,
   parameter logic SERIAL_STOP     = 1'b1,
   parameter int   BITS            = 8,
   parameter int   START_BITS      = 1,
   parameter int   PARITY_BITS     = 0,
   parameter int   STOP_BITS       = 1,
   parameter logic LOWBIT_FIRST    = 1'b1,
   parameter logic EVEN_PARITY     = 1'b1
) (
   input  logic            in_clk,
   input  logic            in_rst,
   input  logic            in_enable,
   input  logic            in_serial,
   output logic            out_ready,
   output logic            out_word_finished,
   output logic [BITS-1:0] out_parallel,
   output logic            out_parity_err,
   output logic            out_frame_err
);

   localparam int CLK_DIV  = MAIN_CLK_HZ / SERIAL_CLK_HZ;
   localparam int HALF_DIV = CLK_DIV / 2;
   localparam int CTR_W    = $clog2(CLK_DIV);
   localparam int BIT_W    = $clog2(BITS + 1);

   typedef enum logic [2:0] {
      ST_READY  = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic              sync1_r;
   logic              sync2_r;
   logic              line_s;
   logic [CTR_W-1:0]  cycle_ctr_r;
   logic [BIT_W-1:0]  bit_ctr_r;
   logic [BIT_W-1:0]  idx_s;
   logic [BITS-1:0]   data_r;
   logic              parity_r;
   logic              par_err_r;
   logic              frame_acc_r;
   logic              sample_s;
   logic              last_bit_s;

   function automatic logic parity_mismatch(input logic sample, input logic expected);
      return sample ^ expected;
   endfunction

   function automatic logic stop_bad(input logic sample);
      return sample ^ SERIAL_STOP;
   endfunction

   assign line_s = sync2_r;

   // State register
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_r <= ST_READY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_READY: begin
            if (in_enable && (line_s == SERIAL_START)) state_next_s = ST_START;
            else                                       state_next_s = ST_READY;
         end
         ST_START: begin
            if (sample_s && (line_s != SERIAL_START)) state_next_s = ST_READY;
            else if (sample_s && last_bit_s)          state_next_s = ST_DATA;
            else                                      state_next_s = ST_START;
         end
         ST_DATA: begin
            if (sample_s && last_bit_s) state_next_s = (PARITY_BITS == 1) ? ST_PARITY : ST_STOP;
            else                        state_next_s = ST_DATA;
         end
         ST_PARITY: begin
            if (sample_s) state_next_s = ST_STOP;
            else          state_next_s = ST_PARITY;
         end
         ST_STOP: begin
            if (sample_s && last_bit_s) state_next_s = ST_READY;
            else                        state_next_s = ST_STOP;
         end
         default: state_next_s = ST_READY;
      endcase
   end

   // Sample-point and bit-position decode; the first start sample is half a bit in
   always_comb begin
      sample_s   = 1'b0;
      last_bit_s = 1'b0;
      idx_s      = bit_ctr_r;
      if ((state_r == ST_START) && (bit_ctr_r == {BIT_W{1'b0}})) begin
         sample_s = (cycle_ctr_r == CTR_W'(HALF_DIV - 1));
      end else if (state_r != ST_READY) begin
         sample_s = (cycle_ctr_r == CTR_W'(CLK_DIV - 1));
      end else begin
         sample_s = 1'b0;
      end
      case (state_r)
         ST_START:  last_bit_s = (bit_ctr_r == BIT_W'(START_BITS - 1));
         ST_DATA:   last_bit_s = (bit_ctr_r == BIT_W'(BITS - 1));
         ST_PARITY: last_bit_s = 1'b1;
         ST_STOP:   last_bit_s = (bit_ctr_r == BIT_W'(STOP_BITS - 1));
         default:   last_bit_s = 1'b0;
      endcase
      if (LOWBIT_FIRST) idx_s = bit_ctr_r;
      else              idx_s = BIT_W'(BITS - 1) - bit_ctr_r;
   end

   // Synchroniser, counters, deserialiser and registered outputs
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         sync1_r           <= SERIAL_INACTIVE;
         sync2_r           <= SERIAL_INACTIVE;
         cycle_ctr_r       <= {CTR_W{1'b0}};
         bit_ctr_r         <= {BIT_W{1'b0}};
         data_r            <= {BITS{1'b0}};
         parity_r          <= 1'b0;
         par_err_r         <= 1'b0;
         frame_acc_r       <= 1'b0;
         out_ready         <= 1'b1;
         out_word_finished <= 1'b0;
         out_parallel      <= {BITS{1'b0}};
         out_parity_err    <= 1'b0;
         out_frame_err     <= 1'b0;
      end else begin
         sync1_r           <= in_serial;
         sync2_r           <= sync1_r;
         out_ready         <= (state_next_s == ST_READY);
         out_word_finished <= 1'b0;

         if ((state_r == ST_READY) || sample_s) cycle_ctr_r <= {CTR_W{1'b0}};
         else                                   cycle_ctr_r <= cycle_ctr_r + CTR_W'(1);

         if (state_next_s != state_r) bit_ctr_r <= {BIT_W{1'b0}};
         else if (sample_s)           bit_ctr_r <= bit_ctr_r + BIT_W'(1);

         case (state_r)
            ST_READY: begin
               if (state_next_s == ST_START) begin
                  parity_r    <= ~EVEN_PARITY;
                  par_err_r   <= 1'b0;
                  frame_acc_r <= 1'b0;
               end
            end
            ST_DATA: begin
               if (sample_s) begin
                  for (int i = 0; i < BITS; i++) begin
                     if (idx_s == BIT_W'(i)) data_r[i] <= line_s;
                  end
                  parity_r <= parity_r ^ line_s;
               end
            end
            ST_PARITY: begin
               if (sample_s) par_err_r <= parity_mismatch(line_s, parity_r);
            end
            ST_STOP: begin
               if (sample_s) begin
                  frame_acc_r <= frame_acc_r | stop_bad(line_s);
                  // A bad stop bit still delivers the word, just flagged
                  if (last_bit_s) begin
                     out_parallel      <= data_r;
                     out_parity_err    <= par_err_r;
                     out_frame_err     <= frame_acc_r | stop_bad(line_s);
                     out_word_finished <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/serial_async_rx.md
Name: serial_async_rx

Overview:
Asynchronous serial (UART-style) receiver, the receive-side counterpart of the team's asynchronous serial transmitter, with an identical frame format. It oversamples the serial line with the main clock and detects the start-bit edge. It samples each bit at its centre, deserialises the data bits, and checks parity and stop bits. Each completed word is presented in parallel with a one-cycle strobe and error flags.

Parameters:
MAIN_CLK_HZ, 50_000_000, main clock frequency
SERIAL_CLK_HZ, 9_600, baud rate; CLK_DIV = MAIN_CLK_HZ / SERIAL_CLK_HZ (integer division), must be >= 4
SERIAL_INACTIVE, 1'b1, idle line level
SERIAL_START, 1'b0, start bit level
SERIAL_STOP, 1'b1, stop bit level
BITS, 8, data bits per word
START_BITS, 1, start bits (1 or 2)
PARITY_BITS, 0, parity bits (0 or 1)
STOP_BITS, 1, stop bits (1 or 2)
LOWBIT_FIRST, 1'b1, 1: first received data bit goes to bit 0; 0: to bit BITS-1
EVEN_PARITY, 1'b1, 1: even parity, 0: odd parity

Ports:
in_clk  input  1  main clock, all logic on rising edge
in_rst  input  1  asynchronous, active-high reset
in_enable  input  1  allow detection of new start bits
in_serial  input  1  serial line (asynchronous to in_clk)
out_ready  output  1  high while idle (state Ready)
out_word_finished  output  1  one-cycle strobe: out_parallel and error flags valid/updated
out_parallel  output  BITS  last received word
out_parity_err  output  1  parity mismatch in last word
out_frame_err  output  1  stop bit not at SERIAL_STOP in last word

Behaviour:
- Reset (async, in_rst=1): state Ready, out_ready=1, out_word_finished=0, out_parallel=0, out_parity_err=0, out_frame_err=0. The synchroniser flops reset to SERIAL_INACTIVE; counters reset to 0. Reset mid-frame aborts the frame with no strobe.
- in_serial passes through a 2-flop synchroniser; all decisions use the synchronised value (2 cycles of input latency).
- States: Ready, ReceiveStart, ReceiveData, ReceiveParity, ReceiveStop.
- Ready: when in_enable=1 and the synchronised line is SERIAL_START, load cycle_ctr=0 and go to ReceiveStart. With in_enable=0, a low line is ignored.
- ReceiveStart: at cycle_ctr = CLK_DIV/2 - 1, re-sample the line.
  - Still SERIAL_START: glitch filter passes; this point becomes the bit-centre reference.
  - Otherwise: return to Ready with no strobe and no flag change.
  - After START_BITS centre samples, go to ReceiveData.
- Sampling cadence: after the start-bit centre, every subsequent bit is sampled exactly CLK_DIV cycles after the previous sample. cycle_ctr runs 0..CLK_DIV-1 and wraps; bit_ctr counts bits within the current state.
- ReceiveData: store sample n at index n (LOWBIT_FIRST=1) or BITS-1-n (LOWBIT_FIRST=0) of a shift/hold register. Running parity is initialised to 0 for even parity and 1 for odd parity, and is XORed with each data bit. After BITS samples, go to ReceiveParity if PARITY_BITS=1, else ReceiveStop.
- ReceiveParity: the parity error is computed as (sample != running parity).
- ReceiveStop: the frame error is set if any stop sample != SERIAL_STOP. After the centre sample of the last stop bit:
  - Next cycle: out_parallel, out_parity_err and out_frame_err are updated and out_word_finished=1 for exactly one cycle.
  - The state returns to Ready in the same cycle, so a start bit beginning in the second half of the stop bit is caught.
- A frame error does not suppress the strobe; data is delivered with the flag set.
- Outputs hold their values between strobes. in_enable going low mid-frame does not abort the frame.
- With PARITY_BITS=0, out_parity_err is always 0.
- out_ready is registered state decode: low from the cycle after the start edge is accepted until the strobe cycle.

Test Plan:
(All with MAIN_CLK_HZ=1_000_000, SERIAL_CLK_HZ=100_000, CLK_DIV=10.)
- 8N1, LOWBIT_FIRST=1, send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1), each bit held 10 cycles -> one strobe, out_parallel=0xA5, both error flags 0, out_ready=1 afterwards.
- LOWBIT_FIRST=0, send 0xA5 MSB first -> out_parallel=0xA5. Send the same line pattern with LOWBIT_FIRST=1 -> 0xA5. Send line pattern 0x3C LSB-first with LOWBIT_FIRST=0 -> out_parallel=0x3C bit-reversed, i.e. 0x3C.
- 8E1, send 0x07 with parity bit 1 -> parity_err=0. Resend with parity bit 0 -> parity_err=1, out_parallel=0x07.
- 8N1, send 0x55 with stop bit driven 0 -> strobe, out_parallel=0x55, frame_err=1. Next clean frame 0x12 -> frame_err=0.
- Line low for 3 cycles only (glitch) -> no strobe, state back to Ready. Back-to-back frames 0x01, 0xFE with no idle gap -> two strobes, values 0x01 then 0xFE.
- Assert in_rst during data bit 4 -> all outputs return to reset values immediately, no strobe. Then send 0x42 -> out_parallel=0x42.
